// File: rtl/lcd_min_writer.sv
// Drives a 4-bit HD44780-style LCD with the four captured values on line 1 and
// the minimum and its position on line 2, refreshed on request.
module lcd_min_writer #(
    parameter int T_PWR  = 750000,
    parameter int T_INIT = 205000,
    parameter int T_E    = 12,
    parameter int T_NIB  = 50,
    parameter int T_BYTE = 2000,
    parameter int T_CLR  = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic [2:0] c,
    input  logic [2:0] d,
    input  logic [1:0] minpos,
    input  logic       upd,
    output logic       ready,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       sf_ce0
);
    localparam int MAXW = T_PWR + T_INIT + T_E + T_NIB + T_BYTE + T_CLR;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, IDLE, WRITE} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD, PH_GAP} phase_t;

    state_t        state, state_nxt;
    phase_t        ph, ph_nxt;
    logic [CW-1:0] cnt, cnt_nxt, gap;
    logic [4:0]    idx, idx_nxt;
    logic          lo, lo_nxt;
    logic          pend, pend_nxt;
    logic          snap, last, sending;
    logic [2:0]    sa, sb, sc, sd, vmin;
    logic [1:0]    smp;
    logic [7:0]    cur_byte;
    logic [3:0]    nib;
    logic          cur_rs;

    // Byte/nibble currently on the bus, and the gap that follows it.
    always_comb begin
        vmin = sa;
        case (smp)
            2'd1:    vmin = sb;
            2'd2:    vmin = sc;
            2'd3:    vmin = sd;
            default: vmin = sa;
        endcase
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        last     = 1'b0;
        case (state)
            INIT: begin
                cur_byte = (idx == 5'd3) ? 8'h02 : 8'h03;
                last     = (idx == 5'd3);
            end
            CFG: begin
                case (idx)
                    5'd0:    cur_byte = 8'h28;
                    5'd1:    cur_byte = 8'h06;
                    5'd2:    cur_byte = 8'h0C;
                    default: cur_byte = 8'h01;
                endcase
                last = (idx == 5'd3);
            end
            WRITE: begin
                cur_rs = !(idx == 5'd0 || idx == 5'd8);
                last   = (idx == 5'd19);
                case (idx)
                    5'd0:    cur_byte = 8'h80;
                    5'd1:    cur_byte = 8'h30 + {5'd0, sa};
                    5'd3:    cur_byte = 8'h30 + {5'd0, sb};
                    5'd5:    cur_byte = 8'h30 + {5'd0, sc};
                    5'd7:    cur_byte = 8'h30 + {5'd0, sd};
                    5'd8:    cur_byte = 8'hC0;
                    5'd9:    cur_byte = 8'h4D;
                    5'd10:   cur_byte = 8'h49;
                    5'd11:   cur_byte = 8'h4E;
                    5'd12:   cur_byte = 8'h3A;
                    5'd13:   cur_byte = 8'h30 + {5'd0, vmin};
                    5'd15:   cur_byte = 8'h50;
                    5'd16:   cur_byte = 8'h4F;
                    5'd17:   cur_byte = 8'h53;
                    5'd18:   cur_byte = 8'h3A;
                    5'd19:   cur_byte = 8'h41 + {6'd0, smp};
                    default: cur_byte = 8'h20;
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
        // Init nibbles travel alone, carried in the low half.
        nib = (state == INIT || lo) ? cur_byte[3:0] : cur_byte[7:4];
        if (state == INIT)                  gap = CW'(T_INIT);
        else if (!lo)                       gap = CW'(T_NIB);
        else if (state == CFG && idx == 5'd3) gap = CW'(T_BYTE + T_CLR);
        else                                gap = CW'(T_BYTE);
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        lo_nxt    = lo;
        pend_nxt  = pend | (upd && state != IDLE);
        snap      = 1'b0;
        case (state)
            PWR_WAIT: begin
                if (cnt == CW'(T_PWR - 1)) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                    ph_nxt    = PH_SETUP;
                    idx_nxt   = '0;
                    lo_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (upd) begin
                    snap      = 1'b1;
                    state_nxt = WRITE;
                    cnt_nxt   = '0;
                    ph_nxt    = PH_SETUP;
                    idx_nxt   = '0;
                    lo_nxt    = 1'b0;
                end
            end
            default: begin
                cnt_nxt = cnt + 1'b1;
                case (ph)
                    PH_SETUP:  if (cnt == CW'(1)) begin ph_nxt = PH_STROBE; cnt_nxt = '0; end
                    PH_STROBE: if (cnt == CW'(T_E - 1)) begin ph_nxt = PH_HOLD; cnt_nxt = '0; end
                    PH_HOLD:   begin ph_nxt = PH_GAP; cnt_nxt = '0; end
                    default: begin
                        if (cnt == gap - 1'b1) begin
                            cnt_nxt = '0;
                            ph_nxt  = PH_SETUP;
                            if (state != INIT && !lo) begin
                                lo_nxt = 1'b1;
                            end else begin
                                lo_nxt  = 1'b0;
                                idx_nxt = idx + 5'd1;
                                if (last) begin
                                    idx_nxt = '0;
                                    case (state)
                                        INIT: state_nxt = CFG;
                                        CFG:  state_nxt = IDLE;
                                        default: begin
                                            // A merged request restarts the refresh directly.
                                            if (pend_nxt) begin
                                                snap     = 1'b1;
                                                pend_nxt = 1'b0;
                                            end else begin
                                                state_nxt = IDLE;
                                            end
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR_WAIT;
            ph    <= PH_SETUP;
            cnt   <= '0;
            idx   <= '0;
            lo    <= 1'b0;
            pend  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sc    <= '0;
            sd    <= '0;
            smp   <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            lo    <= lo_nxt;
            pend  <= pend_nxt;
            if (snap) begin
                sa  <= a;
                sb  <= b;
                sc  <= c;
                sd  <= d;
                smp <= minpos;
            end
        end
    end

    assign sending = (state == INIT || state == CFG || state == WRITE) && ph != PH_GAP;
    assign ready   = (state == IDLE);
    assign lcd_e   = sending && ph == PH_STROBE;
    assign lcd_d   = sending ? nib : 4'h0;
    assign lcd_rs  = sending ? cur_rs : 1'b0;
    assign lcd_rw  = 1'b0;
    assign sf_ce0  = 1'b1;
endmodule

// File: tb/tb_lcd_min_writer.sv
// Decodes the LCD bus into nibbles/bytes and compares them with the display
// contents expected from the inputs at each refresh request.
module tb_lcd_min_writer;
    localparam int T_PWR = 20, T_INIT = 10, T_E = 4, T_NIB = 3, T_BYTE = 8, T_CLR = 16;

    logic       clk = 1'b0, rst_n = 1'b0, upd = 1'b0;
    logic [2:0] a = 0, b = 0, c = 0, d = 0;
    logic [1:0] minpos = 0;
    logic       ready, lcd_e, lcd_rs, lcd_rw, sf_ce0;
    logic [3:0] lcd_d;

    int total = 0, bad = 0;
    int cyc = 0, fall_cyc = 0, rdy_cyc = 0;
    logic [8:0] rx_q[$], exp_q[$];
    logic [3:0] init_q[$];

    lcd_min_writer #(.T_PWR(T_PWR), .T_INIT(T_INIT), .T_E(T_E), .T_NIB(T_NIB),
                     .T_BYTE(T_BYTE), .T_CLR(T_CLR)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .minpos(minpos),
        .upd(upd), .ready(ready), .lcd_d(lcd_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .sf_ce0(sf_ce0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: setup/width/hold checks per strobe, nibble-to-byte assembly.
    initial begin
        logic p1_e, p2_e, p1_rs, p2_rs, cap_rs, hi_rs, have_hi;
        logic [3:0] p1_d, p2_d, cap_d, hi;
        int width, nib_n;
        p1_e = 0; p2_e = 0; p1_rs = 0; p2_rs = 0; p1_d = 0; p2_d = 0;
        cap_rs = 0; cap_d = 0; hi = 0; hi_rs = 0; have_hi = 0; width = 0; nib_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p1_e = 0; p2_e = 0; have_hi = 0; nib_n = 0; width = 0;
            end else begin
                if (lcd_e && !p1_e) begin
                    chk("setup", {p2_e, p1_e, p2_rs, p2_d, p1_rs, p1_d},
                        {2'b00, lcd_rs, lcd_d, lcd_rs, lcd_d});
                    width = 1; cap_rs = lcd_rs; cap_d = lcd_d;
                end else if (lcd_e) begin
                    width++;
                end else if (p1_e) begin
                    chk("e_width", width, T_E);
                    chk("hold", {lcd_rs, lcd_d}, {cap_rs, cap_d});
                    fall_cyc = cyc;
                    if (nib_n < 4) init_q.push_back(cap_d);
                    else if (!have_hi) begin hi = cap_d; hi_rs = cap_rs; have_hi = 1; end
                    else begin
                        chk("rs_pair", cap_rs, hi_rs);
                        rx_q.push_back({cap_rs, hi, cap_d});
                        have_hi = 0;
                    end
                    nib_n++;
                end
                p2_e = p1_e; p2_rs = p1_rs; p2_d = p1_d;
                p1_e = lcd_e; p1_rs = lcd_rs; p1_d = lcd_d;
            end
        end
    end

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < budget) begin @(negedge clk); n++; end
        if (!ready) chk("ready_timeout", 0, 1);
        rdy_cyc = cyc;
    endtask

    task automatic wait_bytes(input int cnt, input int budget);
        int n;
        n = 0;
        while (rx_q.size() < cnt && n < budget) begin @(negedge clk); n++; end
        if (rx_q.size() < cnt) chk("bytes_timeout", rx_q.size(), cnt);
    endtask

    task automatic pulse_upd;
        @(negedge clk); upd = 1'b1;
        @(negedge clk); upd = 1'b0;
    endtask

    // Expected display: line 1 "a b c d", line 2 "MIN:v POS:p".
    task automatic push_line(input logic [2:0] va, vb, vc, vd, input logic [1:0] mp, input int n);
        logic [8:0] l[$];
        logic [2:0] v[4];
        string s1, s2;
        v = '{va, vb, vc, vd};
        s1 = $sformatf("%0d %0d %0d %0d", va, vb, vc, vd);
        s2 = $sformatf("MIN:%0d POS:%c", v[mp], 8'h41 + {6'd0, mp});
        l.push_back({1'b0, 8'h80});
        for (int i = 0; i < s1.len(); i++) l.push_back({1'b1, s1[i]});
        l.push_back({1'b0, 8'hC0});
        for (int i = 0; i < s2.len(); i++) l.push_back({1'b1, s2[i]});
        for (int i = 0; i < n && i < l.size(); i++) exp_q.push_back(l[i]);
    endtask

    task automatic push_cfg;
        exp_q.push_back(9'h028); exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
    endtask

    task automatic check_init;
        logic [3:0] e[4];
        e = '{4'h3, 4'h3, 4'h3, 4'h2};
        chk("init_count", init_q.size(), 4);
        for (int i = 0; i < 4 && i < init_q.size(); i++) chk("init_nib", init_q[i], e[i]);
        init_q.delete();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0) chk(tag, rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        logic [2:0] na, nb, nc, nd;
        logic [1:0] nm;
        repeat (3) @(negedge clk);
        chk("rst_out", {ready, lcd_e, lcd_rs, lcd_d, lcd_rw, sf_ce0}, 9'b000000001);
        rst_n = 1'b1;

        wait_ready(5000);
        check_init();
        push_cfg();
        check_rx("cfg");
        chk("clr_wait", rdy_cyc - fall_cyc, 1 + T_BYTE + T_CLR);

        a = 4; b = 7; c = 1; d = 3; minpos = 2;
        pulse_upd();
        push_line(4, 7, 1, 3, 2, 20);
        chk("busy", ready, 0);
        wait_ready(5000);
        check_rx("w_basic");

        // Requests during a refresh merge into a single follow-up refresh.
        pulse_upd();
        push_line(4, 7, 1, 3, 2, 20);
        wait_bytes(3, 2000);
        a = 0;
        pulse_upd();
        repeat (5) @(negedge clk);
        pulse_upd();
        push_line(0, 7, 1, 3, 2, 20);
        wait_ready(5000);
        repeat (60) @(negedge clk);
        chk("idle_after_merge", ready, 1);
        check_rx("w_merge");

        a = 7; b = 7; c = 7; d = 7; minpos = 3;
        pulse_upd();
        push_line(7, 7, 7, 7, 3, 20);
        wait_ready(5000);
        check_rx("w_all7");

        for (int it = 0; it < 6; it++) begin
            a = 3'($urandom_range(0, 7)); b = 3'($urandom_range(0, 7));
            c = 3'($urandom_range(0, 7)); d = 3'($urandom_range(0, 7));
            minpos = 2'($urandom_range(0, 3));
            pulse_upd();
            push_line(a, b, c, d, minpos, 20);
            if ($urandom_range(0, 1) == 1) begin
                wait_bytes($urandom_range(1, 12), 2000);
                na = 3'($urandom_range(0, 7)); nb = 3'($urandom_range(0, 7));
                nc = 3'($urandom_range(0, 7)); nd = 3'($urandom_range(0, 7));
                nm = 2'($urandom_range(0, 3));
                a = na; b = nb; c = nc; d = nd; minpos = nm;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) pulse_upd();
                push_line(na, nb, nc, nd, nm, 20);
            end
            wait_ready(5000);
            repeat (30) @(negedge clk);
            check_rx("w_rand");
        end

        // Reset in the middle of the 5th byte's strobe, with a request pending.
        a = 5; b = 2; c = 6; d = 1; minpos = 3;
        pulse_upd();
        push_line(5, 2, 6, 1, 3, 4);
        wait_bytes(1, 2000);
        pulse_upd();
        wait_bytes(4, 2000);
        begin
            int n;
            n = 0;
            while (!lcd_e && n < 200) begin @(negedge clk); n++; end
            chk("strobe5_seen", lcd_e, 1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_e", lcd_e, 0);
        chk("rst_mid_out", {ready, lcd_rs, lcd_d}, 6'd0);
        check_rx("abort");
        init_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(5000);
        check_init();
        push_cfg();
        check_rx("recfg");
        repeat (100) @(negedge clk);
        chk("pend_cleared", {ready, 8'(rx_q.size())}, {1'b1, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/lcd_min_writer.md
LCD_MIN_WRITER -- requirements
Module: lcd_min_writer

Interface
REQ-001 Parameter T_PWR, default 750000, power-up wait in clk cycles.
REQ-002 Parameter T_INIT, default 205000, wait after each init nibble in cycles.
REQ-003 Parameter T_E, default 12, lcd_e high width in cycles.
REQ-004 Parameter T_NIB, default 50, gap between the two nibbles of one byte in cycles.
REQ-005 Parameter T_BYTE, default 2000, gap after each byte in cycles.
REQ-006 Parameter T_CLR, default 82000, extra wait after the clear command in cycles.
REQ-007 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Ports a, b, c, d, input, 3 each, the four captured values.
REQ-010 Port minpos, input, 2, index of the minimum value (0=a … 3=d).
REQ-011 Port upd, input, 1, refresh request, level-sampled each cycle.
REQ-012 Port ready, output, 1, high only in IDLE.
REQ-013 Port lcd_d, output, 4, LCD data nibble (DB7..DB4).
REQ-014 Port lcd_e, output, 1, LCD enable strobe.
REQ-015 Port lcd_rs, output, 1, 0 = command, 1 = character data.
REQ-016 Port lcd_rw, output, 1, tied 0 (write only).
REQ-017 Port sf_ce0, output, 1, tied 1 (StrataFlash disabled so the LCD owns the shared bus).

Function
REQ-018 The top FSM SHALL use states PWR_WAIT -> INIT -> CFG -> IDLE <-> WRITE.
REQ-019 PWR_WAIT SHALL hold for T_PWR cycles with lcd_e=0.
REQ-020 INIT SHALL send single nibbles 0x3, 0x3, 0x3, 0x2 (rs=0), each followed by T_INIT cycles.
REQ-021 CFG SHALL send bytes 0x28, 0x06, 0x0C, 0x01 (rs=0); after 0x01 it SHALL wait an extra T_CLR cycles, then enter IDLE.
REQ-022 Each nibble strobe SHALL be: lcd_d/lcd_rs valid 2 cycles -> lcd_e=1 for T_E cycles -> lcd_e=0 with data held 1 cycle.
REQ-023 Each byte SHALL be sent high nibble first, then T_NIB gap, then low nibble, then T_BYTE gap.
REQ-024 In IDLE, upd=1 SHALL snapshot a, b, c, d and minpos into internal registers and enter WRITE on the next cycle.
REQ-025 WRITE SHALL send 20 bytes in order: 0x80; chars "a b c d" (7); 0xC0; "MIN:" v " POS:" p (11).
REQ-026 The digit characters SHALL be 0x30 + value, v SHALL equal the snapshot value selected by minpos, and p SHALL be 0x41 + minpos ('A'..'D').
REQ-027 Address bytes 0x80/0xC0 SHALL use rs=0; all characters SHALL use rs=1.
REQ-028 upd=1 on any cycle while not in IDLE SHALL set a one-deep pending flag; further requests while it is set SHALL be merged.
REQ-029 At the end of WRITE, if pending=1, the block SHALL clear it, re-snapshot the inputs and restart WRITE without passing through IDLE; otherwise it SHALL enter IDLE.
REQ-030 Input changes during WRITE SHALL NOT affect the bytes being sent.
REQ-031 All wait counters SHALL be wide enough for the largest parameter; there is no wrap-around within one wait.

Reset
REQ-032 rst_n=0 SHALL immediately force state=PWR_WAIT, counters=0, pending=0, ready=0, lcd_e=0, lcd_rs=0, lcd_d=0, and clear the snapshot registers.
REQ-033 Reset asserted mid-strobe SHALL drop lcd_e in the same instant, with no completion of the byte.
REQ-034 After release, the full power-up, init and config sequence SHALL rerun before ready=1.

Verification (T_PWR=20, T_INIT=10, T_E=4, T_NIB=3, T_BYTE=8, T_CLR=16)
REQ-035 Reset release, upd=0 -> exactly 4 init nibbles (3,3,3,2), then bytes 28,06,0C,01; ready rises after the T_CLR wait; lcd_e width is 4 in every strobe.
REQ-036 In IDLE, a=4 b=7 c=1 d=3 minpos=2, 1-cycle upd -> bytes 80,'4',' ','7',' ','1',' ','3',C0,'M','I','N',':','1',' ','P','O','S',':','C'; then ready=1.
REQ-037 During REQ-036, change a to 0 and pulse upd twice -> one extra WRITE only, whose first digit is '0'; the first WRITE is unaffected.
REQ-038 All inputs 7, minpos=3 -> line 2 reads "MIN:7 POS:D".
REQ-039 rst_n low during the 5th byte of WRITE -> lcd_e=0 immediately, pending cleared, full init replayed, ready=0 until CFG completes.
